// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave front-end: FSM state encoding,
// wait-counter width and a constant-friendly clog2.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } apb_state_e;

   localparam int CNT_W = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: load, decrement to zero, synchronous clear.
module apb_wait_counter
   import apb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   input  logic             clr,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_if.sv
// APB4 slave front-end for the timer register bank: programmable wait states,
// byte-masked writes, registered read data and PSLVERR on illegal addresses.
module apb_slave_if
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic [DATA_W-1:0]          pwdata,
   input  logic [DATA_W/8-1:0]        pstrb,
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic                       wr_en,
   output logic                       rd_en,
   output logic [clog2(NUM_REGS)-1:0] reg_idx,
   output logic [DATA_W-1:0]          reg_wdata,
   output logic [DATA_W-1:0]          reg_wmask,
   input  logic [DATA_W-1:0]          reg_rdata
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = clog2(BYTES);
   localparam int IDX_W = clog2(NUM_REGS);
   localparam int LIMIT = NUM_REGS * BYTES;
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);
   // The first access cycle already counts as one wait cycle, so load W-1.
   localparam logic [CNT_W-1:0] LOAD_VAL = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

   apb_state_e state_q, state_d;
   logic err_q, err_d;
   logic pready_q, pready_d;
   logic pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic access, err_c, err_sel, fire;
   logic cnt_load, cnt_dec, cnt_clr, cnt_zero;

   always_comb begin
      reg_idx   = IDX_W'(paddr >> OFF_W);
      reg_wdata = pwdata;
      reg_wmask = '0;
      for (int b = 0; b < BYTES; b++) begin
         reg_wmask[b*8 +: 8] = {8{pstrb[b]}};
      end
      err_c  = ((paddr & ADDR_W'(BYTES - 1)) != '0) || (paddr >= ADDR_W'(LIMIT));
      access = psel & penable & rst_n;
   end

   apb_wait_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .clr      (cnt_clr),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (access) state_d = NO_WAIT ? ST_RESP : ST_WAIT;
         ST_WAIT: begin
            if (!psel)         state_d = ST_IDLE;
            else if (cnt_zero) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The zero-wait case strobes straight out of IDLE using the live decode.
   always_comb begin
      cnt_load = (state_q == ST_IDLE) & access & ~NO_WAIT;
      cnt_dec  = (state_q == ST_WAIT) & psel & ~cnt_zero;
      cnt_clr  = (state_q == ST_WAIT) & ~psel;
      fire     = ((state_q == ST_IDLE) & access & NO_WAIT) |
                 ((state_q == ST_WAIT) & access & cnt_zero);
      err_sel  = (state_q == ST_IDLE) ? err_c : err_q;
      err_d    = ((state_q == ST_IDLE) & access) ? err_c : err_q;
      wr_en    = fire & pwrite & ~err_sel;
      rd_en    = fire & ~pwrite & ~err_sel;
      pready_d  = fire;
      pslverr_d = fire & err_sel;
      prdata_d  = prdata_q;
      if (fire && !pwrite) begin
         prdata_d = err_sel ? '0 : reg_rdata;
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_if.sv
// Bench for apb_slave_if: three instances (0, 3 and 4 wait states) on a shared
// bus with per-instance psel, checked against an address/latency model.
module tb_apb_slave_if;
   import apb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic [31:0] prdata_a    [3];
   logic        pready_a    [3];
   logic        pslverr_a   [3];
   logic        wr_en_a     [3];
   logic        rd_en_a     [3];
   logic [3:0]  reg_idx_a   [3];
   logic [31:0] reg_wdata_a [3];
   logic [31:0] reg_wmask_a [3];
   logic [31:0] reg_rdata_a [3];

   logic [31:0] bank     [16];
   logic [31:0] last_prd [3];
   logic        prev_rdy [3];
   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign reg_rdata_a[0] = bank[reg_idx_a[0]];
   assign reg_rdata_a[1] = bank[reg_idx_a[1]];
   assign reg_rdata_a[2] = bank[reg_idx_a[2]];

   apb_slave_if #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[0]),
      .pready(pready_a[0]), .pslverr(pslverr_a[0]), .wr_en(wr_en_a[0]), .rd_en(rd_en_a[0]),
      .reg_idx(reg_idx_a[0]), .reg_wdata(reg_wdata_a[0]), .reg_wmask(reg_wmask_a[0]),
      .reg_rdata(reg_rdata_a[0]));

   apb_slave_if #(.WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[1]),
      .pready(pready_a[1]), .pslverr(pslverr_a[1]), .wr_en(wr_en_a[1]), .rd_en(rd_en_a[1]),
      .reg_idx(reg_idx_a[1]), .reg_wdata(reg_wdata_a[1]), .reg_wmask(reg_wmask_a[1]),
      .reg_rdata(reg_rdata_a[1]));

   apb_slave_if #(.WAIT_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[2]),
      .pready(pready_a[2]), .pslverr(pslverr_a[2]), .wr_en(wr_en_a[2]), .rd_en(rd_en_a[2]),
      .reg_idx(reg_idx_a[2]), .reg_wdata(reg_wdata_a[2]), .reg_wmask(reg_wmask_a[2]),
      .reg_rdata(reg_rdata_a[2]));

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
   endfunction

   function automatic logic [31:0] mask_of(input logic [3:0] st);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (st[b]) m = m | (32'h0000_00FF << (8 * b));
      end
      return m;
   endfunction

   // pready must be a single-cycle pulse and pslverr may only accompany it.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_n) begin
            if (prev_rdy[k]) begin
               checks++;
               if (pready_a[k] === 1'b1) begin
                  failures++;
                  $display("FAIL pready_pulse dut%0d: pready high 2 cycles, required 1", k);
               end
            end
            if (pslverr_a[k] === 1'b1 && pready_a[k] !== 1'b1) begin
               checks++;
               failures++;
               $display("FAIL pslverr_gate dut%0d: pslverr=1 with pready=%b", k, pready_a[k]);
            end
         end
         prev_rdy[k] = pready_a[k];
      end
   end

   // Caller is positioned 1ns after a rising edge; returns the same way.
   task automatic do_xfer(input int k, input bit wr, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input string tag);
      int c, strobe_cyc, strobe_cnt, ready_cyc, w;
      bit exp_err, s_wr, s_err;
      logic [3:0]  s_idx;
      logic [31:0] s_mask, s_wd, s_prd, exp_prd;
      w = wait_of(k);
      exp_err = ((addr % 4) != 0) || (addr >= 12'd64);
      psel = 3'b001 << k; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = wd; pstrb = st;
      @(posedge clk); #1;
      penable = 1'b1;
      c = 1; strobe_cyc = -1; strobe_cnt = 0; ready_cyc = -1;
      s_wr = 1'b0; s_err = 1'b0; s_idx = '0; s_mask = '0; s_wd = '0; s_prd = '0;
      while (ready_cyc < 0 && c < 300) begin
         @(negedge clk);
         if (wr_en_a[k] === 1'b1 || rd_en_a[k] === 1'b1) begin
            strobe_cnt++; strobe_cyc = c; s_wr = wr_en_a[k];
            s_idx = reg_idx_a[k]; s_mask = reg_wmask_a[k]; s_wd = reg_wdata_a[k];
         end
         if (pready_a[k] === 1'b1) begin
            ready_cyc = c; s_err = pslverr_a[k]; s_prd = prdata_a[k];
         end else begin
            @(posedge clk); #1;
            c++;
         end
      end
      @(posedge clk); #1;
      psel = 3'b000; penable = 1'b0;

      checks++;
      if (ready_cyc !== w + 2) begin
         failures++;
         $display("FAIL %s ready_cycle: got T%0d required T%0d", tag, ready_cyc, w + 2);
      end
      checks++;
      if (s_err !== exp_err) begin
         failures++;
         $display("FAIL %s pslverr: got %b required %b", tag, s_err, exp_err);
      end
      if (exp_err) begin
         checks++;
         if (strobe_cnt != 0) begin
            failures++;
            $display("FAIL %s err_strobe: got %0d strobes required 0", tag, strobe_cnt);
         end
      end else begin
         checks++;
         if (strobe_cnt != 1 || strobe_cyc != w + 1) begin
            failures++;
            $display("FAIL %s strobe: got %0d strobes at T%0d required 1 at T%0d",
                     tag, strobe_cnt, strobe_cyc, w + 1);
         end
         checks++;
         if (s_wr !== wr || s_idx !== 4'(addr >> 2)) begin
            failures++;
            $display("FAIL %s strobe_kind: wr=%b idx=%0d required wr=%b idx=%0d",
                     tag, s_wr, s_idx, wr, addr >> 2);
         end
         if (wr) begin
            checks++;
            if (s_mask !== mask_of(st) || s_wd !== wd) begin
               failures++;
               $display("FAIL %s wmask_wdata: got %h/%h required %h/%h",
                        tag, s_mask, s_wd, mask_of(st), wd);
            end
         end
      end
      if (!wr) begin
         exp_prd = exp_err ? 32'h0 : bank[addr >> 2];
         last_prd[k] = exp_prd;
      end
      checks++;
      if (s_prd !== last_prd[k]) begin
         failures++;
         $display("FAIL %s prdata: got %h required %h", tag, s_prd, last_prd[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int k = 0; k < 3; k++) begin
         last_prd[k] = 32'h0;
         prev_rdy[k] = 1'b0;
      end
      for (int i = 0; i < 16; i++) bank[i] = $urandom;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({pready_a[k], pslverr_a[k], wr_en_a[k], rd_en_a[k]} !== 4'b0 || prdata_a[k] !== 32'h0) begin
            failures++;
            $display("FAIL reset dut%0d: rdy=%b err=%b wr=%b rd=%b prdata=%h required all 0",
                     k, pready_a[k], pslverr_a[k], wr_en_a[k], rd_en_a[k], prdata_a[k]);
         end
      end
   endtask

   task automatic test_write_nowait();
      do_xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, "write_nowait");
   endtask

   task automatic test_read_wait();
      bank[2] = 32'h1234_5678;
      do_xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, "read_wait3");
   endtask

   task automatic test_strobes();
      do_xfer(0, 1'b1, 12'h010, $urandom, 4'h5, "strb_5");
      do_xfer(0, 1'b1, 12'h014, $urandom, 4'h0, "strb_0");
      do_xfer(1, 1'b1, 12'h03C, $urandom, 4'hA, "strb_a_last");
   endtask

   task automatic test_errors();
      do_xfer(0, 1'b0, 12'h040, 32'h0, 4'hF, "err_range_rd");
      do_xfer(0, 1'b1, 12'h002, $urandom, 4'hF, "err_misalign_wr");
      do_xfer(1, 1'b0, 12'h101, 32'h0, 4'h0, "err_both_rd_w3");
      do_xfer(2, 1'b1, 12'hFFC, $urandom, 4'hF, "err_top_wr_w4");
   endtask

   task automatic test_abort();
      int bad;
      bad = 0;
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
      paddr = 12'h00C; pwdata = $urandom; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (wr_en_a[2] || rd_en_a[2] || pready_a[2]) bad++;
         @(posedge clk); #1;
      end
      psel = 3'b000; penable = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (wr_en_a[2] || rd_en_a[2] || pready_a[2]) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_quiet: %0d cycles with strobe/pready, required 0", bad);
      end
      checks++;
      if (u_dut4.state_q !== ST_IDLE || u_dut4.u_cnt.cnt_q !== 8'd0) begin
         failures++;
         $display("FAIL abort_idle: state=%0d cnt=%0d required IDLE/0",
                  u_dut4.state_q, u_dut4.u_cnt.cnt_q);
      end
      @(posedge clk); #1;
      do_xfer(2, 1'b0, 12'h00C, 32'h0, 4'h0, "after_abort");
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      psel = 3'b010; penable = 1'b0; pwrite = 1'b0;
      paddr = 12'h020; pstrb = 4'h0;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({pready_a[k], pslverr_a[k], wr_en_a[k], rd_en_a[k]} !== 4'b0 || prdata_a[k] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid dut%0d: rdy=%b err=%b wr=%b rd=%b prdata=%h required all 0",
                     k, pready_a[k], pslverr_a[k], wr_en_a[k], rd_en_a[k], prdata_a[k]);
         end
         last_prd[k] = 32'h0;
      end
      psel = 3'b000; penable = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (wr_en_a[k] || rd_en_a[k] || pready_a[k]) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_release: %0d strobe/pready events, required 0", bad);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      do_xfer(1, 1'b1, 12'h018, $urandom, 4'hF, "b2b_wr");
      do_xfer(1, 1'b0, 12'h018, 32'h0, 4'h0, "b2b_rd");
      do_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, "b2b_rd0");
      do_xfer(0, 1'b1, 12'h000, $urandom, 4'h3, "b2b_wr0");
   endtask

   task automatic test_random();
      int k, r;
      logic [11:0] a;
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         if (r < 6)      a = 12'($urandom_range(0, 15) * 4);
         else if (r < 8) a = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else            a = 12'($urandom_range(64, 4095));
         do_xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "random");
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_write_nowait();
      test_read_wait();
      test_strobes();
      test_errors();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
